// File: rtl/ahfp_fixed_2_float_if.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | ahfp_fixed_2_float_if : valid/ready bus, fixed in -> float out    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
interface ahfp_fixed_2_float_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/ahfp_fixed_2_float.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | ahfp_fixed_2_float : 3-stage signed fixed point -> IEEE-754 single|
// | Rounding: AHFP_ROUND_NEAREST_EN (RNE) else truncate. Revision: 1.0|
// +------------------------------------------------------------------+
module ahfp_fixed_2_float #(
  parameter int FRAC_BITS = 29
) (
  input  logic                 clk,
  input  logic                 rst,
  ahfp_fixed_2_float_if.slave  io_bus
);
  localparam logic [7:0] c_BIAS = 8'(127 - FRAC_BITS);

  logic        r_v1, r_v2, r_v3;
  logic        w_adv1, w_adv2, w_adv3;
  logic        r_s1_sign;
  logic [32:0] r_s1_mag;
  logic        r_s2_sign, r_s2_zero;
  logic [4:0]  r_s2_p;
  logic [22:0] r_s2_mant;
  logic [31:0] r_out_data;

  logic [32:0] w_mag;
  logic [4:0]  w_p;
  logic [5:0]  w_amt;
  logic [32:0] w_norm;
  logic [7:0]  w_exp;
  logic [22:0] w_mant;

  // A stage may load whenever it is empty or its occupant moves on this cycle.
  assign w_adv3 = !r_v3 || io_bus.out_ready;
  assign w_adv2 = !r_v2 || w_adv3;
  assign w_adv1 = !r_v1 || w_adv2;

  assign io_bus.in_ready  = w_adv1;
  assign io_bus.out_valid = r_v3;
  assign io_bus.out_data  = r_out_data;

  // Sign-extend before negating so 0x80000000 yields +2^31.
  assign w_mag = io_bus.in_data[31] ? (33'd0 - {io_bus.in_data[31], io_bus.in_data})
                                    : {1'b0, io_bus.in_data};

  always_comb begin
    w_p = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (r_s1_mag[i]) w_p = 5'(i);
    end
  end

  assign w_amt  = 6'd32 - {1'b0, w_p};
  assign w_norm = r_s1_mag << w_amt;

`ifdef AHFP_ROUND_NEAREST_EN
  logic [2:0] r_s2_grs;
  logic       w_inc;
  logic       w_carry;

  assign w_inc = r_s2_grs[2] & (r_s2_grs[1] | r_s2_grs[0] | r_s2_mant[0]);
  assign {w_carry, w_mant} = {1'b0, r_s2_mant} + {23'd0, w_inc};
  assign w_exp = {3'd0, r_s2_p} + c_BIAS + {7'd0, w_carry};
`else
  logic w_unused_grs;

  assign w_unused_grs = ^w_norm[8:0];
  assign w_mant = r_s2_mant;
  assign w_exp  = {3'd0, r_s2_p} + c_BIAS;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      r_v3       <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_mag   <= 33'd0;
      r_s2_sign  <= 1'b0;
      r_s2_zero  <= 1'b1;
      r_s2_p     <= 5'd0;
      r_s2_mant  <= 23'd0;
`ifdef AHFP_ROUND_NEAREST_EN
      r_s2_grs   <= 3'd0;
`endif
      r_out_data <= 32'd0;
    end else begin
      if (w_adv1) begin
        r_v1 <= io_bus.in_valid;
        if (io_bus.in_valid) begin
          r_s1_sign <= io_bus.in_data[31];
          r_s1_mag  <= w_mag;
        end
      end
      if (w_adv2) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_s2_sign <= r_s1_sign;
          r_s2_zero <= !w_norm[32];
          r_s2_p    <= w_p;
          r_s2_mant <= w_norm[31:9];
`ifdef AHFP_ROUND_NEAREST_EN
          r_s2_grs  <= {w_norm[8], w_norm[7], |w_norm[6:0]};
`endif
        end
      end
      if (w_adv3) begin
        r_v3 <= r_v2;
        if (r_v2) begin
          r_out_data <= r_s2_zero ? 32'd0 : {r_s2_sign, w_exp, w_mant};
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_ahfp_fixed_2_float.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | tb_ahfp_fixed_2_float : directed + random bench with ref model    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_ahfp_fixed_2_float;
  localparam int FRAC = 29;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ahfp_fixed_2_float_if bus();

  ahfp_fixed_2_float #(.FRAC_BITS(FRAC)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  bit          acc, ov, ir;
  logic [31:0] od;
  logic [31:0] held;
  logic [31:0] rd;
  bit          riv, rrdy, stale;
  int          idx, sent;
  logic [31:0] bp_in[4];
  logic [31:0] bp_exp[4];
`ifdef AHFP_ROUND_NEAREST_EN
  localparam logic [31:0] MAXPOS_EXP = 32'h40800000;
`else
  localparam logic [31:0] MAXPOS_EXP = 32'h407FFFFF;
`endif

  // Reference: exact integer magnitude, quotient/remainder rounding.
  function automatic logic [31:0] ref_f2f(input logic [31:0] x);
    longint v, m, q, rem, half;
    int     p, e;
    bit     s;
    v = longint'($signed(x));
    s = (v < 0);
    m = s ? -v : v;
    if (m == 0) return 32'd0;
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    if (p <= 23) begin
      q = m << (23 - p); rem = 0; half = 1;
    end else begin
      q = m >> (p - 23); rem = m - (q << (p - 23)); half = longint'(1) << (p - 24);
    end
`ifdef AHFP_ROUND_NEAREST_EN
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == (longint'(1) << 24)) begin
      q = longint'(1) << 23; p = p + 1;
    end
`endif
    e = p - FRAC + 127;
    return {s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_data();
    logic [31:0] r;
    case ($urandom_range(0, 3))
      0: r = $urandom;
      1: r = 32'($urandom_range(0, 255));
      2: r = 32'd0 - 32'($urandom_range(1, 1000));
      default: r = 32'd1 << $urandom_range(0, 31);
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock: drive at negedge, sample 1ns later, transfers happen at next posedge.
  task automatic tick(input bit iv, input logic [31:0] id, input bit ordy, input logic [31:0] expv);
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    #1;
    ir  = bus.in_ready;
    acc = iv && ir;
    ov  = bus.out_valid;
    od  = bus.out_data;
    if (ov && ordy) begin
      check("result_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("result_value", od, exp_q.pop_front());
    end
    if (acc) exp_q.push_back(expv);
    @(posedge clk);
  endtask

  initial begin
    bp_in  = '{32'h20000000, 32'hE0000000, 32'h00000001, 32'h10000000};
    bp_exp = '{32'h3F800000, 32'hBF800000, 32'h31000000, 32'h3F000000};
    rst = 1'b1; bus.in_valid = 1'b0; bus.in_data = 32'd0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_data", bus.out_data, 32'd0);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);

    // Latency
    tick(1'b1, 32'h20000000, 1'b1, 32'h3F800000);
    check("lat_accept", 32'(acc), 32'd1);
    tick(1'b0, 32'd0, 1'b1, 32'd0); check("lat_c1", 32'(ov), 32'd0);
    tick(1'b0, 32'd0, 1'b1, 32'd0); check("lat_c2", 32'(ov), 32'd0);
    tick(1'b0, 32'd0, 1'b1, 32'd0); check("lat_c3", 32'(ov), 32'd1);

    // Back-to-back, negatives, edges
    tick(1'b1, 32'h20000000, 1'b1, 32'h3F800000);
    tick(1'b1, 32'h10000000, 1'b1, 32'h3F000000);
    tick(1'b1, 32'h08000000, 1'b1, 32'h3E800000);
    tick(1'b1, 32'hE0000000, 1'b1, 32'hBF800000);
    tick(1'b1, 32'h80000000, 1'b1, 32'hC0800000);
    tick(1'b1, 32'h00000000, 1'b1, 32'h00000000);
    tick(1'b1, 32'h00000001, 1'b1, 32'h31000000);
    tick(1'b1, 32'h7FFFFFFF, 1'b1, MAXPOS_EXP);
    repeat (5) tick(1'b0, 32'd0, 1'b1, 32'd0);
    check("directed_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      tick(1'b1, bp_in[idx], 1'b0, bp_exp[idx]);
      if (acc) idx++;
      if (c == 3) held = od;
      if (c > 3) check("bp_hold", od, held);
      if (c == 5) begin
        check("bp_in_ready_low", 32'(ir), 32'd0);
        check("bp_out_valid", 32'(ov), 32'd1);
      end
    end
    check("bp_accepted", 32'(idx), 32'd3);
    for (int c = 0; c < 12; c++) begin
      if (idx < 4) begin
        tick(1'b1, bp_in[idx], 1'b1, bp_exp[idx]);
        if (acc) idx++;
      end else begin
        tick(1'b0, 32'd0, 1'b1, 32'd0);
      end
    end
    check("bp_all_accepted", 32'(idx), 32'd4);
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-stream
    tick(1'b1, 32'h20000000, 1'b0, 32'h3F800000);
    tick(1'b1, 32'h10000000, 1'b0, 32'h3F000000);
    @(negedge clk); rst = 1'b1; bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    exp_q.delete();
    stale = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick(1'b0, 32'd0, 1'b1, 32'd0);
      if (ov) stale = 1'b1;
    end
    check("rst_no_stale", 32'(stale), 32'd0);

    // Random traffic
    sent = 0;
    for (int c = 0; c < 40000 && sent < 10000; c++) begin
      riv  = ($urandom_range(0, 3) != 0);
      rrdy = ($urandom_range(0, 3) != 0);
      rd   = rand_data();
      tick(riv, rd, rrdy, ref_f2f(rd));
      if (acc) sent++;
    end
    repeat (10) tick(1'b0, 32'd0, 1'b1, 32'd0);
    check("rand_sent", 32'(sent), 32'd10000);
    check("rand_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
